// File: rtl/bank_capture_sequencer_pkg.sv
// Shared types and constants for the input register bank capture sequencer.
package bank_capture_pkg;

  typedef enum logic [1:0] {IDLE, REQ, LOAD, NEXT} state_e;

  localparam int N_SLOTS      = 13;
  localparam int SLOT_IRQ     = 0;
  localparam int SLOT_READY   = 1;
  localparam int SLOT_RTC0    = 2;
  localparam int SLOT_KEY     = 11;
  localparam int SLOT_NEWDATA = 12;

  // RTC register map: sec..yr, then timer. Entry [0] is read first.
  localparam logic [8:0][7:0] RTC_ADDR = {8'hF1, 8'h28, 8'h27, 8'h26, 8'h25,
                                          8'h24, 8'h23, 8'h22, 8'h21};

  // Address of the idx-th register of a sweep; out-of-table indices read as 0.
  function automatic logic [7:0] rtc_addr(input int idx);
    rtc_addr = (idx >= 0 && idx < 9) ? RTC_ADDR[idx] : 8'h00;
  endfunction

endpackage

// File: rtl/bank_capture_sequencer_kb_edge.sv
// Keyboard strobe edge detector; drives the one-cycle key/newdata slot enables.
module bank_cap_kb_edge (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_kb_strobe,
  input  logic       i_kb_clr,
  output logic [1:0] o_kb_en     // [0] key slot, [1] newdata slot
);

  logic r_kb_q;
  logic r_en_key;
  logic r_en_new;
  logic w_rise;

  assign w_rise = i_kb_strobe & ~r_kb_q;

  // A rising strobe loads both slots; kb_clr reloads only newdata. Both merge into one pulse.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_kb_q   <= 1'b0;
      r_en_key <= 1'b0;
      r_en_new <= 1'b0;
    end else begin
      r_kb_q   <= i_kb_strobe;
      r_en_key <= w_rise;
      r_en_new <= w_rise | i_kb_clr;
    end
  end

  assign o_kb_en = {r_en_new, r_en_key};

endmodule

// File: rtl/bank_capture_sequencer.sv
// Sequences RTC reads into bank slots 2..10, keeps status slots live, forwards key enables.
module bank_capture_sequencer
  import bank_capture_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int ACK_TIMEOUT = 255,
  parameter int N_RTC       = 9
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_kb_strobe,
  input  logic                 i_kb_clr,
  output logic                 o_rd_req,
  output logic [7:0]           o_rd_addr,
  input  logic                 i_rd_ack,
  input  logic [7:0]           i_rd_data,
  output logic [7:0]           o_entrada,
  output logic [N_SLOTS-1:0]   o_en,
  output logic                 o_busy,
  output logic                 o_sweep_done,
  output logic                 o_timeout_err
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam int IW = $clog2(N_RTC);

  state_e          r_state, w_state_nx;
  logic [IW-1:0]   r_idx, w_idx_nx;
  logic            r_pending, w_pending_nx;
  logic [RW-1:0]   r_ref_cnt;
  logic [WW-1:0]   r_wait;
  logic [7:0]      r_entrada;
  logic            r_stat_en;
  logic            r_timeout_err;
  logic [1:0]      w_kb_en;
  logic [N_RTC-1:0] w_rtc_en;
  logic            w_ref_wrap, w_sweep_req, w_last, w_ack_hit, w_tmo_hit;

  assign w_ref_wrap  = (r_ref_cnt == RW'(REFRESH_DIV - 1));
  assign w_sweep_req = i_start | w_ref_wrap;
  assign w_last      = (r_idx == IW'(N_RTC - 1));
  // Ack wins over a timeout landing in the same cycle.
  assign w_ack_hit   = (r_state == REQ) & i_rd_ack;
  assign w_tmo_hit   = (r_state == REQ) & ~i_rd_ack & (r_wait == WW'(ACK_TIMEOUT - 1));

  // Free-running refresh divider; the wrap cycle requests a sweep.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_ref_cnt <= '0;
    else          r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + RW'(1);
  end

  // Ack wait counter: counts REQ cycles of the current register, zero elsewhere.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)              r_wait <= '0;
    else if (r_state == REQ)   r_wait <= r_wait + WW'(1);
    else                       r_wait <= '0;
  end

  // FSM state, sweep index and the collapsed follow-up request.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_idx     <= w_idx_nx;
      r_pending <= w_pending_nx;
    end
  end

  // Next-state logic; requests arriving mid-sweep fold into a single pending flag.
  always_comb begin
    w_state_nx   = r_state;
    w_idx_nx     = r_idx;
    w_pending_nx = r_pending;
    case (r_state)
      IDLE: begin
        w_pending_nx = 1'b0;
        if (w_sweep_req) begin
          w_state_nx = REQ;
          w_idx_nx   = '0;
        end
      end
      REQ: begin
        w_pending_nx = r_pending | w_sweep_req;
        if (w_ack_hit)      w_state_nx = LOAD;
        else if (w_tmo_hit) w_state_nx = NEXT;
      end
      LOAD: begin
        w_pending_nx = r_pending | w_sweep_req;
        w_state_nx   = NEXT;
      end
      NEXT: begin
        if (w_last) begin
          // A request seen in this very cycle is served like a pending one.
          w_pending_nx = 1'b0;
          w_idx_nx     = '0;
          w_state_nx   = (r_pending | w_sweep_req) ? REQ : IDLE;
        end else begin
          w_pending_nx = r_pending | w_sweep_req;
          w_idx_nx     = r_idx + IW'(1);
          w_state_nx   = REQ;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Data word only moves on an accepted ack; status enables go live after reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_entrada <= '0;
      r_stat_en <= 1'b0;
    end else begin
      r_stat_en <= 1'b1;
      if (w_ack_hit) r_entrada <= i_rd_data;
    end
  end

  // Sticky timeout flag; a fresh timeout outranks a clearing start.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)       r_timeout_err <= 1'b0;
    else if (w_tmo_hit) r_timeout_err <= 1'b1;
    else if (i_start)   r_timeout_err <= 1'b0;
  end

  bank_cap_kb_edge u_kb (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_kb_strobe (i_kb_strobe),
    .i_kb_clr    (i_kb_clr),
    .o_kb_en     (w_kb_en)
  );

  assign w_rtc_en = (r_state == LOAD) ? (N_RTC'(1) << r_idx) : '0;

  // Assemble the slot enables: status, one RTC slot at most, keyboard pair.
  always_comb begin
    o_en                          = '0;
    o_en[SLOT_IRQ]                = r_stat_en;
    o_en[SLOT_READY]              = r_stat_en;
    o_en[SLOT_RTC0 +: N_RTC]      = w_rtc_en;
    o_en[SLOT_KEY]                = w_kb_en[0];
    o_en[SLOT_NEWDATA]            = w_kb_en[1];
  end

  assign o_rd_req      = (r_state == REQ);
  assign o_rd_addr     = (r_state == REQ) ? rtc_addr(int'(r_idx)) : 8'h00;
  assign o_entrada     = r_entrada;
  assign o_sweep_done  = (r_state == NEXT) & w_last;
  // Busy drops together with the final sweep_done unless another sweep follows.
  assign o_busy        = (r_state != IDLE) &
                         ~((r_state == NEXT) & w_last & ~r_pending & ~w_sweep_req);
  assign o_timeout_err = r_timeout_err;

endmodule
